// File: rtl/psum_writeback_stage.sv
// Serializes one group of saturated partial sums into 32-bit output-buffer words.
// D16 packs two lanes per word, D32 emits one lane per word; next group is taken on the last word.
module psum_writeback_stage #(
  parameter int PEROW   = 4,
  parameter int PSUMDWD = 32,
  parameter int ADDRW   = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            PS_rdy,
  output logic                            PS_ack,
  input  logic [PEROW-1:0][PSUMDWD-1:0]   i_sum,
  input  logic                            i_d16,
  input  logic [ADDRW-1:0]                i_waddr,
  output logic                            PO_rdy,
  input  logic                            PO_ack,
  output logic [31:0]                     o_data,
  output logic [ADDRW-1:0]                o_addr,
  output logic                            o_last,
  output logic                            o_busy
);

  // state | meaning
  // IDLE  | no group held, upstream may hand one over
  // SEND  | group held, presenting word 'beat' to the output buffer
  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam int BW = $clog2(PEROW);

  state_t                         state_q;
  logic [BW-1:0]                  beat_q;
  logic [PEROW-1:0][PSUMDWD-1:0]  sum_q;
  logic                           d16_q;
  logic [ADDRW-1:0]               base_q;

  logic [BW-1:0]  nb_m1;
  logic           last;
  logic           up_xfer;
  logic [31:0]    w32;
  logic [31:0]    w16;

  assign nb_m1   = d16_q ? BW'(PEROW/2 - 1) : BW'(PEROW - 1);
  assign last    = (state_q == SEND) && (beat_q == nb_m1);
  assign PS_ack  = (state_q == IDLE) || (last && PO_ack);
  assign up_xfer = PS_rdy && PS_ack;

  always_comb begin
    w32 = '0;
    w16 = '0;
    for (int i = 0; i < PEROW; i++) begin
      if (BW'(i) == beat_q) w32 = sum_q[i][31:0];
    end
    // Upper bits of each lane are already zero in D16, so only [15:0] is packed.
    for (int i = 0; i < PEROW/2; i++) begin
      if (BW'(i) == beat_q) w16 = {sum_q[2*i+1][15:0], sum_q[2*i][15:0]};
    end
  end

  assign o_busy = (state_q == SEND);
  assign PO_rdy = o_busy;
  assign o_last = last;
  assign o_data = o_busy ? (d16_q ? w16 : w32) : 32'd0;
  assign o_addr = o_busy ? ADDRW'(base_q + ADDRW'(beat_q)) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      sum_q   <= '0;
      d16_q   <= 1'b0;
      base_q  <= '0;
    end else if (up_xfer) begin
      state_q <= SEND;
      beat_q  <= '0;
      sum_q   <= i_sum;
      d16_q   <= i_d16;
      base_q  <= i_waddr;
    end else if (state_q == SEND && PO_ack) begin
      if (last) begin
        state_q <= IDLE;
        beat_q  <= '0;
      end else begin
        beat_q  <= beat_q + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_psum_writeback_stage.sv
// Scoreboard bench for psum_writeback_stage: directed groups push hand-computed words,
// a negedge monitor pops and compares every accepted output word.
module tb_psum_writeback_stage;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              PS_rdy;
  logic              PS_ack;
  logic [3:0][31:0]  i_sum;
  logic              i_d16;
  logic [7:0]        i_waddr;
  logic              PO_rdy;
  logic              PO_ack;
  logic [31:0]       o_data;
  logic [7:0]        o_addr;
  logic              o_last;
  logic              o_busy;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  addr;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  psum_writeback_stage #(.PEROW(4), .PSUMDWD(32), .ADDRW(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .PS_rdy(PS_rdy), .PS_ack(PS_ack),
    .i_sum(i_sum), .i_d16(i_d16), .i_waddr(i_waddr),
    .PO_rdy(PO_rdy), .PO_ack(PO_ack),
    .o_data(o_data), .o_addr(o_addr), .o_last(o_last), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic exp_word(input logic [31:0] d, input logic [7:0] a, input logic l);
    exp_t e;
    e.data = d; e.addr = a; e.last = l;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted word must match the queue head; PS_ack follows IDLE || last&&ack.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      check("ps_ack", {31'd0, PS_ack}, {31'd0, (!o_busy) || (o_last && PO_ack)});
      if (PO_rdy && PO_ack) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got data=0x%0h addr=0x%0h, expected none", o_data, o_addr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_data", o_data, e.data);
          check("word_addr", {24'd0, o_addr}, {24'd0, e.addr});
          check("word_last", {31'd0, o_last}, {31'd0, e.last});
        end
      end
    end
  end

  // Hands a group over; returns #1 after the capturing edge with PS_rdy left as 'hold'.
  task automatic send_group(input logic d16, input logic [3:0][31:0] s,
                            input logic [7:0] wa, input logic hold);
    logic acc;
    int   n;
    PS_rdy = 1'b1; i_d16 = d16; i_sum = s; i_waddr = wa;
    acc = 1'b0; n = 0;
    while (!acc && n < 30) begin
      @(negedge i_clk); acc = PS_ack;
      @(posedge i_clk); #1;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL upstream_timeout: got no PS_ack, expected PS_ack within 30 cycles");
    end
    PS_rdy = hold;
    i_sum = '1;
  endtask

  task automatic drain();
    int n = 0;
    while ((o_busy || exp_q.size() != 0) && n < 50) begin
      @(negedge i_clk); n++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", {31'd0, o_busy}, 32'd0);
    @(posedge i_clk); #1;
  endtask

  initial begin
    int qn;
    i_rst = 1'b1; PS_rdy = 1'b0; PO_ack = 1'b1; i_d16 = 1'b0; i_sum = '0; i_waddr = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_po_rdy", {31'd0, PO_rdy}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_ps_ack", {31'd0, PS_ack}, 32'd1);
    check("rst_data", o_data, 32'd0);
    check("rst_addr", {24'd0, o_addr}, 32'd0);
    check("rst_last", {31'd0, o_last}, 32'd0);
    @(posedge i_clk); #1;

    // D32 basic
    exp_word(32'h11111111, 8'h10, 1'b0);
    exp_word(32'h22222222, 8'h11, 1'b0);
    exp_word(32'h33333333, 8'h12, 1'b0);
    exp_word(32'h44444444, 8'h13, 1'b1);
    send_group(1'b0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 8'h10, 1'b0);
    drain();

    // D16 packing
    exp_word(32'h7FFF0001, 8'h20, 1'b0);
    exp_word(32'h12348000, 8'h21, 1'b1);
    send_group(1'b1, {32'h00001234, 32'h00008000, 32'h00007FFF, 32'h00000001}, 8'h20, 1'b0);
    drain();

    // Backpressure on beat 1
    exp_word(32'hA0A0A0A0, 8'h30, 1'b0);
    exp_word(32'hB1B1B1B1, 8'h31, 1'b0);
    exp_word(32'hC2C2C2C2, 8'h32, 1'b0);
    exp_word(32'hD3D3D3D3, 8'h33, 1'b1);
    send_group(1'b0, {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0}, 8'h30, 1'b0);
    @(posedge i_clk); #1;
    PO_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("bp_rdy", {31'd0, PO_rdy}, 32'd1);
      check("bp_data", o_data, 32'hB1B1B1B1);
      check("bp_addr", {24'd0, o_addr}, 32'h31);
      @(posedge i_clk); #1;
    end
    PO_ack = 1'b1;
    drain();

    // Back-to-back groups, zero bubbles
    exp_word(32'h00000100, 8'h00, 1'b0);
    exp_word(32'h00000101, 8'h01, 1'b0);
    exp_word(32'h00000102, 8'h02, 1'b0);
    exp_word(32'h00000103, 8'h03, 1'b1);
    exp_word(32'h00000200, 8'h40, 1'b0);
    exp_word(32'h00000201, 8'h41, 1'b0);
    exp_word(32'h00000202, 8'h42, 1'b0);
    exp_word(32'h00000203, 8'h43, 1'b1);
    send_group(1'b0, {32'h103, 32'h102, 32'h101, 32'h100}, 8'h00, 1'b1);
    fork
      send_group(1'b0, {32'h203, 32'h202, 32'h201, 32'h200}, 8'h40, 1'b0);
      begin
        for (int k = 0; k < 8; k++) begin
          @(negedge i_clk);
          check("b2b_rdy", {31'd0, PO_rdy}, 32'd1);
        end
        @(negedge i_clk);
        check("b2b_gap_after", {31'd0, PO_rdy}, 32'd0);
      end
    join
    drain();

    // Address wrap
    exp_word(32'h0000000A, 8'hFE, 1'b0);
    exp_word(32'h0000000B, 8'hFF, 1'b0);
    exp_word(32'h0000000C, 8'h00, 1'b0);
    exp_word(32'h0000000D, 8'h01, 1'b1);
    send_group(1'b0, {32'hD, 32'hC, 32'hB, 32'hA}, 8'hFE, 1'b0);
    drain();

    // Reset during beat 1 discards the held group
    exp_word(32'h00005555, 8'h50, 1'b0);
    exp_word(32'h00006666, 8'h51, 1'b0);
    exp_word(32'h00007777, 8'h52, 1'b0);
    exp_word(32'h00008888, 8'h53, 1'b1);
    send_group(1'b0, {32'h8888, 32'h7777, 32'h6666, 32'h5555}, 8'h50, 1'b0);
    @(posedge i_clk); #1;
    PO_ack = 1'b0; i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    qn = exp_q.size();
    check("rst_mid_remaining", qn, 3);
    exp_q.delete();
    @(negedge i_clk);
    check("rst_mid_po_rdy", {31'd0, PO_rdy}, 32'd0);
    check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    check("rst_mid_ps_ack", {31'd0, PS_ack}, 32'd1);
    @(posedge i_clk); #1;
    PO_ack = 1'b1;
    exp_word(32'h00020001, 8'h60, 1'b0);
    exp_word(32'h00040003, 8'h61, 1'b1);
    send_group(1'b1, {32'h4, 32'h3, 32'h2, 32'h1}, 8'h60, 1'b0);
    drain();

    repeat (2) @(posedge i_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
